// File: rtl/ram_program_loader.sv
// ram_program_loader: streams a program image into the 32x8 RAM and,
// when LOADER_VERIFY_EN is defined, reads it back to check the sum.
// Ports: clock, reset_n (async, active low); start/abort/byte_count
// control; in_valid/in_ready/in_data byte stream; ram_we/ram_address/
// ram_wdata drive the RAM, ram_rdata is its 1-cycle read data;
// busy/done/error/checksum report status.
module ram_program_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] byte_count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int VW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE, LOAD, VERIFY, DONE, ERROR
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] idx;
  logic          xfer;
  logic          last;

  assign in_ready = (state == LOAD);
  assign xfer     = in_ready & in_valid;
  assign last     = (idx + CW'(1)) == count;
  assign busy     = (state == LOAD) || (state == VERIFY);
  assign done     = (state == DONE);

`ifdef LOADER_VERIFY_EN
  logic [VW-1:0]         vcnt;
  logic [DATA_WIDTH-1:0] rsum;
  logic [DATA_WIDTH-1:0] rsum_next;

  assign error     = (state == ERROR);
  assign rsum_next = rsum + ram_rdata;
`else
  logic unused_rdata;

  assign error        = 1'b0;
  assign unused_rdata = ^ram_rdata;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ram_we      <= 1'b0;
      ram_address <= '0;
      ram_wdata   <= '0;
      checksum    <= '0;
      count       <= '0;
      idx         <= '0;
`ifdef LOADER_VERIFY_EN
      vcnt        <= '0;
      rsum        <= '0;
`endif
    end else begin
      ram_we <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE, DONE, ERROR: begin
            if (start) begin
              // zero selects a full-depth load
              count    <= (byte_count == '0)
                        ? {1'b1, {ADDR_WIDTH{1'b0}}}
                        : {1'b0, byte_count};
              checksum <= '0;
              idx      <= '0;
              state    <= LOAD;
            end
          end
          LOAD: begin
            if (xfer) begin
              ram_we      <= 1'b1;
              ram_address <= BASE + idx[ADDR_WIDTH-1:0];
              ram_wdata   <= in_data;
              checksum    <= checksum + in_data;
              idx         <= idx + CW'(1);
              if (last) begin
`ifdef LOADER_VERIFY_EN
                vcnt  <= '0;
                rsum  <= '0;
                state <= VERIFY;
`else
                state <= DONE;
`endif
              end
            end
          end
`ifdef LOADER_VERIFY_EN
          VERIFY: begin
            // read data lags the issued address by two edges
            vcnt <= vcnt + VW'(1);
            if (vcnt < VW'(count))
              ram_address <= BASE + vcnt[ADDR_WIDTH-1:0];
            if (vcnt >= VW'(2))
              rsum <= rsum_next;
            if (vcnt == VW'(count) + VW'(1))
              state <= (rsum_next == checksum) ? DONE : ERROR;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ram_program_loader.md
Name: ram_program_loader

Overview:
- Initiator-side companion to the 32x8 synchronous RAM. Loads a program image into RAM at run time from a byte stream, replacing hard-coded preload.
- Accepts bytes over a valid/ready stream and drives the RAM write/address/data pins.
- Holds the processor off the RAM while it works, then reports done/error plus a running checksum.

Parameters:
- ADDR_WIDTH, 5, RAM address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 8, RAM/stream data width.
- BASE_ADDR, 0, first RAM address written; subsequent addresses wrap modulo 2^ADDR_WIDTH.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse, begins a load; ignored while busy.
- abort  in  1  synchronous abort, returns to IDLE.
- byte_count  in  ADDR_WIDTH  bytes to load, latched on start; 0 means 2^ADDR_WIDTH.
- in_valid  in  1  stream byte valid.
- in_data  in  DATA_WIDTH  stream byte.
- in_ready  out  1  loader accepts byte this cycle.
- ram_we  out  1  RAM write enable (registered).
- ram_address  out  ADDR_WIDTH  RAM address (registered).
- ram_wdata  out  DATA_WIDTH  RAM write data (registered).
- ram_rdata  in  DATA_WIDTH  RAM read data (registered inside RAM, 1-cycle latency).
- busy  out  1  load or verify in progress; processor must not access RAM.
- done  out  1  load finished successfully; level until next start.
- error  out  1  verify mismatch; level until next start.
- checksum  out  DATA_WIDTH  sum mod 2^DATA_WIDTH of bytes accepted.

Behaviour:
- Reset (async, reset_n=0): state IDLE; ram_we=0, ram_address=0, ram_wdata=0, busy=0, done=0, error=0, checksum=0, in_ready=0.
- Reset mid-load: outputs go to reset values immediately. RAM contents already written are left untouched.
- States: IDLE, LOAD, VERIFY, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - Latch count (0 maps to 2^ADDR_WIDTH).
  - Clear done, error and checksum; idx=0.
  - Go to LOAD next cycle.
- LOAD:
  - in_ready = 1 (combinational from state).
  - Each posedge with in_valid&in_ready: ram_we<=1, ram_address<=(BASE_ADDR+idx) mod depth, ram_wdata<=in_data, checksum<=checksum+in_data (truncated), idx++.
  - Posedge without a transfer: ram_we<=0, address/data hold.
  - The RAM performs the write one cycle after acceptance.
  - On the transfer where idx reaches count, next state is VERIFY (or DONE; see optional feature) and in_ready drops the following cycle.
- VERIFY (ram_we=0 throughout):
  - Issues addresses BASE_ADDR..BASE_ADDR+count-1 (wrapping), one per cycle.
  - Address registered at posedge t yields ram_rdata valid after posedge t+1; it is accumulated at posedge t+2.
  - Pipelined: count+2 cycles total.
  - If the readback sum equals checksum, go to DONE, else ERROR.
- busy = 1 in LOAD and VERIFY only.
- done = 1 in DONE only; error = 1 in ERROR only.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- abort in any state:
  - Next state IDLE; ram_we<=0.
  - done and error cleared; checksum holds.
- Wrap: BASE_ADDR+idx beyond depth-1 wraps to 0. Count = depth overwrites every location exactly once.

Optional Feature:
- Macro LOADER_VERIFY_EN.
- Defined: VERIFY state present as above; error can assert.
- Undefined:
  - LOAD goes directly to DONE the cycle after the final write is issued.
  - error is tied to 0.
  - VERIFY logic and readback accumulator are absent.

Test Plan:
- BASE_ADDR=0, start with count=3, stream 0x80,0x3E,0x80 with in_valid continuous -> ram_we high 3 cycles at addresses 0,1,2 with those data; checksum=0x3E; done=1, error=0, busy=0 afterwards.
- Same load with in_valid low 2 cycles between each byte -> ram_we pulses only on accept cycles; addresses/data identical; checksum=0x3E.
- BASE_ADDR=30, count=0 (32 bytes of value idx) -> writes go to addr 30,31,0..29; every RAM word written once; checksum=0xF0; done=1.
- LOADER_VERIFY_EN defined; RAM model forces addr 1 readback to 0x00 on load 0x80,0x3E,0x80 -> error=1, done=0 after count+2 verify cycles.
- Reset_n pulled low after 2 of 4 bytes accepted -> all outputs zero asynchronously; state IDLE; subsequent start with count=1 and byte 0x1E -> addr BASE_ADDR written, checksum=0x1E, done=1.
- start and abort asserted together in IDLE; then abort mid-LOAD -> state stays IDLE, ram_we=0 the next cycle, busy=0, done=0, error=0.
